// File: rtl/clk_rst_pkg.sv
// Shared encodings for the clock/reset controller: FSM states, Mode values and
// the Mode-to-state decode used when leaving RESET or following Mode.
package clk_rst_pkg;

   typedef enum logic [2:0] {
      ST_RESET     = 3'd0,
      ST_RUN       = 3'd1,
      ST_HALT      = 3'd2,
      ST_STEP_WAIT = 3'd3,
      ST_STEP_EXEC = 3'd4
   } state_t;

   localparam logic [1:0] MODE_RUN      = 2'b00;
   localparam logic [1:0] MODE_HALT     = 2'b01;
   localparam logic [1:0] MODE_STEP     = 2'b10;
   localparam logic [1:0] MODE_HALT_ALT = 2'b11;

   // 11 is reserved and behaves exactly like halt.
   function automatic state_t mode_target(input logic [1:0] mode);
      state_t t;
      case (mode)
         MODE_RUN:  t = ST_RUN;
         MODE_STEP: t = ST_STEP_WAIT;
         default:   t = ST_HALT;
      endcase
      return t;
   endfunction

endpackage

// File: rtl/clk_rst_ctrl_ce_div.sv
// One clock-enable channel: free counter compared against a live divide value,
// producing a registered one-cycle pulse every div+1 advancing cycles.
module ce_div #(
   parameter int DIV_W = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             clr,
   input  logic             adv,
   input  logic [DIV_W-1:0] div,
   output logic             hit,
   output logic             ce,
   output logic [DIV_W-1:0] cnt
);

   logic at_limit;

   // ">=" rather than "==" so a live decrease below cnt fires on the next advance
   // instead of running the counter round 2^DIV_W.
   assign at_limit = (cnt >= div);
   assign hit      = adv && at_limit;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt <= '0;
         ce  <= 1'b0;
      end else begin
         ce <= hit && !clr;
         if (clr) begin
            cnt <= '0;
         end else if (adv) begin
            cnt <= at_limit ? '0 : cnt + 1'b1;
         end
      end
   end

endmodule

// File: rtl/clk_rst_ctrl.sv
// Clock-enable and core-reset controller: stretched core reset, run/halt/
// single-step sequencing and N_CH divided clock-enable channels.
module clk_rst_ctrl
   import clk_rst_pkg::*;
#(
   parameter int N_CH       = 2,
   parameter int DIV_W      = 16,
   parameter int RST_CYCLES = 16
) (
   input  logic                  Clk,
   input  logic                  Rst,
   input  logic [N_CH*DIV_W-1:0] Div,
   input  logic [1:0]            Mode,
   input  logic                  Step,
   input  logic                  Sw_Rst,
   output logic [N_CH-1:0]       Ce,
   output logic                  Core_Rst,
   output logic                  Running,
   output logic                  Step_Done,
   output state_t                Dbg_State
);

   localparam int RC_W = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;
   localparam logic [RC_W-1:0] RC_LAST = RC_W'(RST_CYCLES - 1);

   state_t            state;
   state_t            state_nxt;
   logic [RC_W-1:0]   rst_cnt;
   logic              stretch_done;
   logic              adv;
   logic              exec_hit;
   logic              done_pend;
   logic [N_CH-1:0]   hit;

   assign stretch_done = (rst_cnt == RC_LAST);
   assign Dbg_State    = state;

   // Handshake-free control: Mode and Sw_Rst are levels sampled every cycle,
   // Step is a pulse honoured only in STEP_WAIT; Sw_Rst overrides everything.

   always_ff @(posedge Clk or negedge Rst) begin
      if (!Rst) begin
         state <= ST_RESET;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      if (Sw_Rst) begin
         state_nxt = ST_RESET;
      end else begin
         case (state)
            ST_RESET: begin
               if (stretch_done) state_nxt = mode_target(Mode);
            end
            ST_RUN, ST_HALT: begin
               state_nxt = mode_target(Mode);
            end
            ST_STEP_WAIT: begin
               state_nxt = mode_target(Mode);
               if ((state_nxt == ST_STEP_WAIT) && Step) state_nxt = ST_STEP_EXEC;
            end
            ST_STEP_EXEC: begin
               // A step runs to the core enable pulse regardless of Mode changes.
               if (hit[0]) state_nxt = mode_target(Mode);
            end
            default: state_nxt = ST_RESET;
         endcase
      end
   end

   always_comb begin
      adv      = 1'b0;
      exec_hit = 1'b0;
      if (!Sw_Rst) begin
         adv      = (state == ST_RUN) || (state == ST_STEP_EXEC);
         exec_hit = (state == ST_STEP_EXEC) && hit[0];
      end
   end

   always_ff @(posedge Clk or negedge Rst) begin
      if (!Rst) begin
         rst_cnt <= '0;
      end else if (Sw_Rst || (state != ST_RESET)) begin
         rst_cnt <= '0;
      end else if (!stretch_done) begin
         rst_cnt <= rst_cnt + 1'b1;
      end
   end

   // Core_Rst/Running are registered copies of the next state so they line up
   // with the state register; Step_Done trails the final Ce[0] by one cycle.
   always_ff @(posedge Clk or negedge Rst) begin
      if (!Rst) begin
         Core_Rst  <= 1'b1;
         Running   <= 1'b0;
         done_pend <= 1'b0;
         Step_Done <= 1'b0;
      end else begin
         Core_Rst  <= (state_nxt == ST_RESET);
         Running   <= (state_nxt == ST_RUN);
         done_pend <= exec_hit;
         Step_Done <= done_pend && !Sw_Rst;
      end
   end

   for (genvar k = 0; k < N_CH; k++) begin : g_ch
      logic [DIV_W-1:0] cnt_k;

      ce_div #(
         .DIV_W (DIV_W)
      ) u_ce_div (
         .clk   (Clk),
         .rst_n (Rst),
         .clr   (Sw_Rst),
         .adv   (adv),
         .div   (Div[k*DIV_W +: DIV_W]),
         .hit   (hit[k]),
         .ce    (Ce[k]),
         .cnt   (cnt_k)
      );
   end

endmodule

// File: doc/clk_rst_ctrl.md
CLK_RST_CTRL -- requirements
Module: clk_rst_ctrl

Interface
REQ-001 SHALL have parameter N_CH, default 2, meaning number of clock-enable channels; channel 0 is the core enable.
REQ-002 SHALL have parameter DIV_W, default 16, meaning width of each channel divide value.
REQ-003 SHALL have parameter RST_CYCLES, default 16, meaning core reset stretch length in cycles (>=1).
REQ-004 SHALL have port Clk  input  1  single system clock, all logic rising-edge.
REQ-005 SHALL have port Rst  input  1  asynchronous active-low reset.
REQ-006 SHALL have port Div  input  N_CH*DIV_W  per-channel divide value; channel k at bits [k*DIV_W +: DIV_W].
REQ-007 SHALL have port Mode  input  2  00 run, 01 halt, 10 single-step, 11 treated as halt.
REQ-008 SHALL have port Step  input  1  single-cycle step request pulse.
REQ-009 SHALL have port Sw_Rst  input  1  synchronous software reset request, level.
REQ-010 SHALL have port Ce  output  N_CH  one-cycle clock-enable pulses, one per channel.
REQ-011 SHALL have port Core_Rst  output  1  active-high synchronous reset to the core.
REQ-012 SHALL have port Running  output  1  high while FSM is in RUN.
REQ-013 SHALL have port Step_Done  output  1  one-cycle pulse when a step completes.

Function
REQ-014 SHALL implement FSM states RESET, RUN, HALT, STEP_WAIT, STEP_EXEC.
REQ-015 SHALL, in RESET, hold Core_Rst=1 and count RST_CYCLES cycles, then leave RESET on the cycle the count reaches RST_CYCLES-1.
REQ-016 SHALL leave RESET for RUN if Mode=00, STEP_WAIT if Mode=10, else HALT.
REQ-017 SHALL, from RUN/HALT/STEP_WAIT, follow Mode each cycle: 00->RUN, 10->STEP_WAIT, 01/11->HALT.
REQ-018 SHALL, in STEP_WAIT, move to STEP_EXEC on Step=1; Step in any other state is ignored.
REQ-019 SHALL, in STEP_EXEC, run all channel counters until Ce[0] pulses once, then return to STEP_WAIT (or Mode-selected state) and pulse Step_Done the following cycle.
REQ-020 SHALL keep per-channel counter cnt_k of DIV_W bits, advancing only in RUN or STEP_EXEC.
REQ-021 SHALL, when advancing, pulse Ce[k]=1 and load cnt_k=0 if cnt_k>=Div_k, else increment cnt_k; Ce[k] period is Div_k+1 cycles, Div_k=0 gives Ce every cycle.
REQ-022 SHALL compare against live Div; a decrease below cnt_k causes a pulse on the next advancing cycle, no wrap past 2^DIV_W.
REQ-023 SHALL freeze counters (hold value) and drive Ce=0 in HALT and STEP_WAIT.
REQ-024 SHALL drive Ce=0 and Running=0 whenever Core_Rst=1.
REQ-025 SHALL, on Sw_Rst=1 in any state, enter RESET next cycle, clear all counters and restart the stretch count; Sw_Rst held keeps the stretch count at 0.
REQ-026 SHALL give Sw_Rst priority over Step and Mode in the same cycle; an in-progress STEP_EXEC is abandoned without Step_Done.
REQ-027 SHALL register all outputs (no combinational input-to-output path).

Reset
REQ-028 SHALL, on Rst=0, asynchronously enter RESET with Core_Rst=1, Ce=0, Running=0, Step_Done=0, counters=0, stretch count=0.
REQ-029 SHALL begin the RST_CYCLES stretch on the first Clk edge after Rst deasserts.

Structure
REQ-030 SHALL place FSM state encoding and Mode encoding constants in the shared package clk_rst_pkg.
REQ-031 SHALL implement one channel as sub-module ce_div (counter, compare, pulse), instantiated N_CH times in a generate loop.

Verification
REQ-032 SHALL verify reset stretch: Rst low 3 cycles then high, Mode=00 -> Core_Rst stays 1 for exactly 16 cycles after release, then Running=1.
REQ-033 SHALL verify division: Div0=3, Div1=0, Mode=00 -> Ce[0] every 4th cycle, Ce[1] every cycle.
REQ-034 SHALL verify halt: Mode 00->01 mid-count with cnt0=2, hold 10 cycles, return to 00 -> no Ce during halt, next Ce[0] 2 cycles after resume (Div0=3).
REQ-035 SHALL verify single-step: Mode=10, Div0=3, Step pulse -> exactly one Ce[0] within 4 cycles, Step_Done one cycle later, no further Ce until next Step.
REQ-036 SHALL verify Sw_Rst during STEP_EXEC -> Core_Rst=1 next cycle, counters 0, no Step_Done, 16-cycle stretch restarts.
REQ-037 SHALL verify live Div decrease: cnt0=10, Div0 changed 15->4 -> Ce[0] on next advancing cycle, then period 5.
